z80bd_int_ctrl: RTL and testbench

Vectored interrupt controller for the Z80 board CPLD, sitting between the interrupt sources (16550 `U_INT`, an internal 50 Hz timer, a software request) and the Z80 `INT` pin. It latches and masks requests, drives `INT` low, and supplies an IM2 vector byte during the interrupt-acknowledge cycle (`M1` and `IORQ` both low). Its mask, vector base and pending registers are Z80 I/O ports next to the memory-mapper page ports 0x10–0x13. All Z80 bus inputs are asynchronous and are synchronised into the `CLK_24MHz` domain.

---
 rtl/z80bd_pkg.sv | 33 +++
 rtl/z80bd_sync_fall.sv | 30 +++
 rtl/z80bd_int_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_z80bd_int_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z80bd_pkg.sv
// Shared constants, source ids and FSM state type for the Z80 board
// interrupt controller.
package z80bd_pkg;

  localparam int         TICK_DIV_DEFAULT  = 480000;
  localparam logic [7:0] PORT_BASE_DEFAULT = 8'h14;

  localparam logic [7:0] OFS_MASK  = 8'd0;
  localparam logic [7:0] OFS_VBASE = 8'd1;
  localparam logic [7:0] OFS_PEND  = 8'd2;

  localparam logic [1:0] SRC_TIMER = 2'd0;
  localparam logic [1:0] SRC_UART  = 2'd1;
  localparam logic [1:0] SRC_SOFT  = 2'd2;
  localparam logic [1:0] SRC_SPUR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RECOVER = 2'd2
  } int_state_e;

  // Lowest set bit wins; an empty request set yields the spurious id.
  function automatic logic [1:0] pick_src(input logic [2:0] req);
    logic [1:0] id;
    if (req[0])      id = SRC_TIMER;
    else if (req[1]) id = SRC_UART;
    else if (req[2]) id = SRC_SOFT;
    else             id = SRC_SPUR;
    return id;
  endfunction

endpackage

// File: rtl/z80bd_sync_fall.sv
// Two-flop synchroniser for an active-low asynchronous strobe, resetting
// to the inactive level, with a one-cycle falling-edge pulse.
module z80bd_sync_fall (
  input  logic clk,
  input  logic rst,
  input  logic async_n,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= async_n;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/z80bd_int_ctrl.sv
// Vectored IM2 interrupt controller: latches timer/UART/soft requests,
// drives the Z80 INT pin and serves mask/vbase/pend I/O ports and the ack vector.
module z80bd_int_ctrl
  import z80bd_pkg::*;
#(
  parameter int         TICK_DIV  = TICK_DIV_DEFAULT,
  parameter logic [7:0] PORT_BASE = PORT_BASE_DEFAULT
) (
  input  logic       CLK_24MHz,
  input  logic       RES,
  input  logic       IORQ,
  input  logic       M1,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] A,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  input  logic       U_INT,
  output logic       INT
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic iowr_lvl_unused;
  logic iowr_fall;
  logic iord_lvl;
  logic iord_fall_unused;
  logic ack_lvl;
  logic ack_fall;
  logic uint_n_lvl;
  logic uint_rise_unused;

  z80bd_sync_fall u_sync_wr (
    .clk     (CLK_24MHz),
    .rst     (RES),
    .async_n (IORQ | WR),
    .level   (iowr_lvl_unused),
    .fall    (iowr_fall)
  );

  z80bd_sync_fall u_sync_rd (
    .clk     (CLK_24MHz),
    .rst     (RES),
    .async_n (IORQ | RD),
    .level   (iord_lvl),
    .fall    (iord_fall_unused)
  );

  z80bd_sync_fall u_sync_ack (
    .clk     (CLK_24MHz),
    .rst     (RES),
    .async_n (M1 | IORQ),
    .level   (ack_lvl),
    .fall    (ack_fall)
  );

  // U_INT is active-high; inverting it lets the reset-to-1 synchroniser idle inactive.
  z80bd_sync_fall u_sync_uint (
    .clk     (CLK_24MHz),
    .rst     (RES),
    .async_n (~U_INT),
    .level   (uint_n_lvl),
    .fall    (uint_rise_unused)
  );

  logic hit_mask;
  logic hit_vbase;
  logic hit_pend;
  logic hit_any;

  assign hit_mask  = (A == PORT_BASE + OFS_MASK);
  assign hit_vbase = (A == PORT_BASE + OFS_VBASE);
  assign hit_pend  = (A == PORT_BASE + OFS_PEND);
  assign hit_any   = hit_mask | hit_vbase | hit_pend;

  logic [CNT_W-1:0] tmr_cnt;
  logic             tick;

  assign tick = (tmr_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge CLK_24MHz) begin
    if (RES)       tmr_cnt <= '0;
    else if (tick) tmr_cnt <= '0;
    else           tmr_cnt <= tmr_cnt + 1'b1;
  end

  logic [2:0] mask;
  logic [4:0] vbase;
  logic       pend_tmr;
  logic       pend_soft;
  logic [2:0] pend;
  logic [2:0] req;

  assign pend = {pend_soft, ~uint_n_lvl, pend_tmr};
  assign req  = pend & mask;

  int_state_e state;
  int_state_e state_next;
  logic [1:0] src;
  logic [1:0] src_next;

  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      state <= IDLE;
      src   <= SRC_TIMER;
    end else begin
      state <= state_next;
      src   <= src_next;
    end
  end

  always_comb begin
    state_next = state;
    src_next   = src;
    unique case (state)
      IDLE: begin
        if (ack_fall) begin
          state_next = ACK;
          src_next   = pick_src(req);
        end
      end
      ACK:     if (ack_lvl) state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An acknowledge detected in the same cycle as a write strobe suppresses the write.
  logic ack_enter;
  logic wr_go;
  logic soft_set;
  logic clr_tmr;
  logic clr_soft;

  assign ack_enter = (state == IDLE) && ack_fall;
  assign wr_go     = (state == IDLE) && iowr_fall && !ack_fall;
  assign soft_set  = wr_go && hit_pend && D_IN[7];
  assign clr_tmr   = (wr_go && hit_pend && D_IN[0]) ||
                     (ack_enter && (src_next == SRC_TIMER));
  assign clr_soft  = (wr_go && hit_pend && D_IN[2]) ||
                     (ack_enter && (src_next == SRC_SOFT));

  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      mask      <= '0;
      vbase     <= '0;
      pend_tmr  <= 1'b0;
      pend_soft <= 1'b0;
    end else begin
      if (wr_go && hit_mask)  mask  <= D_IN[2:0];
      if (wr_go && hit_vbase) vbase <= D_IN[7:3];
      if (tick)         pend_tmr <= 1'b1;
      else if (clr_tmr) pend_tmr <= 1'b0;
      if (soft_set)      pend_soft <= 1'b1;
      else if (clr_soft) pend_soft <= 1'b0;
    end
  end

  logic [7:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (hit_mask)       rd_data = {5'b0, mask};
    else if (hit_vbase) rd_data = {vbase, 3'b0};
    else if (hit_pend)  rd_data = {5'b0, pend};
  end

  logic       int_n_next;
  logic       oe_next;
  logic [7:0] dout_next;

  // Outputs follow the upcoming state so the vector appears together with ACK.
  always_comb begin
    int_n_next = 1'b1;
    oe_next    = 1'b0;
    dout_next  = '0;
    unique case (state_next)
      IDLE: begin
        int_n_next = ~|req;
        if (!iord_lvl && hit_any) begin
          oe_next   = 1'b1;
          dout_next = rd_data;
        end
      end
      ACK: begin
        oe_next   = 1'b1;
        dout_next = {vbase, src_next, 1'b0};
      end
      RECOVER: begin
        oe_next = 1'b0;
      end
      default: begin
        oe_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      INT   <= 1'b1;
      D_OE  <= 1'b0;
      D_OUT <= '0;
    end else begin
      INT   <= int_n_next;
      D_OE  <= oe_next;
      D_OUT <= dout_next;
    end
  end

endmodule

// File: tb/tb_z80bd_int_ctrl.sv
// Directed bench for z80bd_int_ctrl: register access table followed by
// hand-written interrupt/ack sequences with hand-computed vectors.
`timescale 1ns/1ps
module tb_z80bd_int_ctrl;

  logic       clk;
  logic       res;
  logic       iorq;
  logic       m1;
  logic       rd;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       u_int;
  logic       int_n;

  int vectors;
  int miscompares;
  int cyc;

  z80bd_int_ctrl #(
    .TICK_DIV  (1000),
    .PORT_BASE (8'h14)
  ) dut (
    .CLK_24MHz (clk),
    .RES       (res),
    .IORQ      (iorq),
    .M1        (m1),
    .RD        (rd),
    .WR        (wr),
    .A         (addr),
    .D_IN      (d_in),
    .D_OUT     (d_out),
    .D_OE      (d_oe),
    .U_INT     (u_int),
    .INT       (int_n)
  );

  initial clk = 1'b0;
  always #20.833 clk = ~clk;

  always @(posedge clk) begin
    if (res) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic       is_wr;
    logic [7:0] a;
    logic [7:0] data;
    logic       exp_oe;
    logic [7:0] exp_dout;
    logic       exp_int;
  } vec_t;

  vec_t tbl[18];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic doReset();
    res  = 1'b1;
    iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
    addr = a; d_in = d;
    iorq = 1'b0; wr = 1'b0;
    repeat (4) @(negedge clk);
    iorq = 1'b1; wr = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic busRead(input logic [7:0] a, output logic oe, output logic [7:0] dout);
    addr = a;
    iorq = 1'b0; rd = 1'b0;
    repeat (4) @(negedge clk);
    oe = d_oe; dout = d_out;
    iorq = 1'b1; rd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkRead(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic       oe;
    logic [7:0] dout;
    busRead(a, oe, dout);
    checkOutput({name, "_oe"}, {7'b0, oe}, 8'h01);
    checkOutput(name, dout, exp);
  endtask

  // Full acknowledge cycle; leaves the bench one cycle after RECOVER.
  task automatic ackCycle(input string name, input logic [7:0] exp_vec);
    m1 = 1'b0; iorq = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput({name, "_oe"}, {7'b0, d_oe}, 8'h01);
    checkOutput({name, "_vec"}, d_out, exp_vec);
    checkOutput({name, "_int"}, {7'b0, int_n}, 8'h01);
    m1 = 1'b1; iorq = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput({name, "_rec_oe"}, {7'b0, d_oe}, 8'h00);
    checkOutput({name, "_rec_int"}, {7'b0, int_n}, 8'h01);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic       oe;
    logic [7:0] dout;
    if (v.is_wr) begin
      busWrite(v.a, v.data);
    end else begin
      busRead(v.a, oe, dout);
      checkOutput($sformatf("tbl%0d_oe", idx), {7'b0, oe}, {7'b0, v.exp_oe});
      checkOutput($sformatf("tbl%0d_dout", idx), dout, v.exp_dout);
    end
    checkOutput($sformatf("tbl%0d_int", idx), {7'b0, int_n}, {7'b0, v.exp_int});
  endtask

  initial begin
    logic low_seen;
    vectors = 0; miscompares = 0;
    res = 1'b1; iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
    addr = 8'h00; d_in = 8'h00; u_int = 1'b0;

    //             wr    addr   data   oe    dout   int
    tbl[0]  = '{1'b0, 8'h14, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 8'h15, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 8'h16, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 8'h17, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[4]  = '{1'b1, 8'h14, 8'hFD, 1'b0, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 8'h14, 8'h00, 1'b1, 8'h05, 1'b1};
    tbl[6]  = '{1'b1, 8'h15, 8'hAF, 1'b0, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 8'h15, 8'h00, 1'b1, 8'hA8, 1'b1};
    tbl[8]  = '{1'b1, 8'h16, 8'h80, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'h16, 8'h00, 1'b1, 8'h04, 1'b0};
    tbl[10] = '{1'b1, 8'h16, 8'h04, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 8'h16, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 8'h16, 8'h85, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 8'h16, 8'h00, 1'b1, 8'h04, 1'b0};
    tbl[14] = '{1'b1, 8'h14, 8'h02, 1'b0, 8'h00, 1'b1};
    tbl[15] = '{1'b0, 8'h14, 8'h00, 1'b1, 8'h02, 1'b1};
    tbl[16] = '{1'b1, 8'h16, 8'h04, 1'b0, 8'h00, 1'b1};
    tbl[17] = '{1'b0, 8'h16, 8'h00, 1'b1, 8'h00, 1'b1};

    doReset();
    checkOutput("reset_int", {7'b0, int_n}, 8'h01);
    checkOutput("reset_oe", {7'b0, d_oe}, 8'h00);
    checkOutput("reset_dout", d_out, 8'h00);
    for (int i = 0; i < 18; i++) applyStimulus(tbl[i], i);

    // 1 ms idle with everything masked: INT never asserts, timer pend latches.
    doReset();
    low_seen = 1'b0;
    for (int i = 0; i < 24000; i++) begin
      @(negedge clk);
      if (int_n !== 1'b1) low_seen = 1'b1;
    end
    checkOutput("idle_int_low_seen", {7'b0, low_seen}, 8'h00);
    checkRead("idle_pend", 8'h16, 8'h01);

    // UART request through a full ack.
    doReset();
    busWrite(8'h14, 8'h07);
    busWrite(8'h15, 8'hA8);
    u_int = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("uart_int_early", {7'b0, int_n}, 8'h01);
    @(negedge clk);
    checkOutput("uart_int_low", {7'b0, int_n}, 8'h00);
    ackCycle("uart_ack", 8'hAA);
    checkOutput("uart_int_held", {7'b0, int_n}, 8'h00);
    checkRead("uart_pend_held", 8'h16, 8'h02);
    u_int = 1'b0;
    repeat (4) @(negedge clk);
    checkRead("uart_pend_drop", 8'h16, 8'h00);
    checkOutput("uart_int_drop", {7'b0, int_n}, 8'h01);

    // Timer tick (due at cycle 1000 after reset) and UART pending together.
    u_int = 1'b1;
    while (cyc < 1010) @(negedge clk);
    checkRead("both_pend", 8'h16, 8'h03);
    ackCycle("both_ack_timer", 8'hA8);
    checkOutput("both_int_reassert", {7'b0, int_n}, 8'h00);
    checkRead("both_pend_after", 8'h16, 8'h02);
    ackCycle("both_ack_uart", 8'hAA);
    u_int = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("both_int_idle", {7'b0, int_n}, 8'h01);

    // Software request, acked and then cleared by write.
    busWrite(8'h16, 8'h80);
    checkRead("soft_pend", 8'h16, 8'h04);
    ackCycle("soft_ack", 8'hAC);
    checkRead("soft_pend_acked", 8'h16, 8'h00);
    busWrite(8'h16, 8'h80);
    checkOutput("soft_int_low", {7'b0, int_n}, 8'h00);
    busWrite(8'h16, 8'h04);
    checkOutput("soft_int_cleared", {7'b0, int_n}, 8'h01);

    // Spurious ack: mask removed after INT fell.
    busWrite(8'h16, 8'h80);
    checkOutput("spur_int_low", {7'b0, int_n}, 8'h00);
    busWrite(8'h14, 8'h00);
    ackCycle("spur_ack", 8'hAE);
    checkRead("spur_pend", 8'h16, 8'h04);
    busWrite(8'h16, 8'h04);

    // Reset pulsed while the vector is being driven.
    busWrite(8'h14, 8'h07);
    busWrite(8'h16, 8'h80);
    m1 = 1'b0; iorq = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_ack_oe", {7'b0, d_oe}, 8'h01);
    checkOutput("rst_ack_vec", d_out, 8'hAC);
    res = 1'b1; m1 = 1'b1; iorq = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_oe", {7'b0, d_oe}, 8'h00);
    checkOutput("rst_mid_int", {7'b0, int_n}, 8'h01);
    checkOutput("rst_mid_dout", d_out, 8'h00);
    res = 1'b0;
    repeat (4) @(negedge clk);
    checkRead("rst_mask", 8'h14, 8'h00);
    checkRead("rst_vbase", 8'h15, 8'h00);
    checkRead("rst_pend", 8'h16, 8'h00);
    checkOutput("rst_int_final", {7'b0, int_n}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
